// File: rtl/dm_arbiter_pkg.sv
// ---- dm_arbiter_pkg : shared encodings for the data-memory arbiter ---- Rev 1.0
`default_nettype none

package dm_arbiter_pkg;

  localparam logic [2:0] OP_W = 3'b000;
  localparam logic [2:0] OP_B = 3'b001;
  localparam logic [2:0] OP_H = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_EXT = 1'b1
  } req_id_t;

  function automatic logic op_legal(input logic [2:0] op);
    return (op == OP_W) || (op == OP_B) || (op == OP_H);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dm_lane_gen.sv
// ---- dm_lane_gen : byte-lane enables and lane-replicated store data ---- Rev 1.0
`default_nettype none

module dm_lane_gen
  import dm_arbiter_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] lane_wdata,
  output logic        misalign
);

  always_comb begin
    be         = 4'b0000;
    lane_wdata = wdata;
    misalign   = 1'b0;
    case (op)
      OP_W: begin
        be       = 4'b1111;
        misalign = (addr_lo != 2'b00);
      end
      OP_H: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{wdata[15:0]}};
        misalign   = addr_lo[0];
      end
      OP_B: begin
        be         = 4'b0001 << addr_lo;
        lane_wdata = {4{wdata[7:0]}};
      end
      default: begin
        be = 4'b0000;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/dm_arbiter.sv
// ---- dm_arbiter : round-robin cpu/ext sharing of a single-port data memory ---- Rev 1.0
`default_nettype none

module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int DEPTH  = 3072,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [2:0]        cpu_op,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_err,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [31:0]       ext_addr,
  input  logic [31:0]       ext_wdata,
  output logic              ext_ack,
  output logic              ext_err,
  output logic [31:0]       ext_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [29:0] DEPTH_LIM = 30'(DEPTH);

  state_t            state, state_nxt;
  req_id_t           last_grant, grant_id;
  logic              any_req;
  logic              sel_we;
  logic [2:0]        sel_op;
  logic [31:0]       sel_addr, sel_wdata;
  logic [3:0]        gen_be;
  logic [31:0]       gen_wdata;
  logic              gen_misalign;
  logic              sel_err;

  req_id_t           hold_id;
  logic              hold_we, hold_err;
  logic [ADDR_W-1:0] hold_idx;
  logic [3:0]        hold_be;
  logic [31:0]       hold_wdata;
  logic [31:0]       cpu_rdata_q, ext_rdata_q, resp_data;

  // Round-robin: on a tie the requester not served last wins.
  always_comb begin
    any_req  = cpu_req | ext_req;
    grant_id = REQ_CPU;
    if (cpu_req && ext_req)
      grant_id = (last_grant == REQ_EXT) ? REQ_CPU : REQ_EXT;
    else if (ext_req)
      grant_id = REQ_EXT;

    sel_we    = cpu_we;
    sel_op    = cpu_op;
    sel_addr  = cpu_addr;
    sel_wdata = cpu_wdata;
    if (grant_id == REQ_EXT) begin
      sel_we    = ext_we;
      sel_op    = OP_W;
      sel_addr  = ext_addr;
      sel_wdata = ext_wdata;
    end
    sel_err = gen_misalign | ~op_legal(sel_op) | (sel_addr[31:2] >= DEPTH_LIM);
  end

  dm_lane_gen u_lane_gen (
    .op         (sel_op),
    .addr_lo    (sel_addr[1:0]),
    .wdata      (sel_wdata),
    .be         (gen_be),
    .lane_wdata (gen_wdata),
    .misalign   (gen_misalign)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (any_req) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_RESP;
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Memory strobes decode from state, so asserting reset kills any write at once.
  always_comb begin
    mem_en    = (state == ST_ISSUE) && !hold_err;
    mem_we    = mem_en && hold_we;
    mem_addr  = mem_en ? hold_idx   : '0;
    mem_be    = mem_en ? hold_be    : 4'b0000;
    mem_wdata = mem_en ? hold_wdata : 32'h0;

    resp_data = hold_err ? 32'h0 : mem_rdata;
    cpu_ack   = (state == ST_RESP) && (hold_id == REQ_CPU);
    ext_ack   = (state == ST_RESP) && (hold_id == REQ_EXT);
    cpu_err   = cpu_ack && hold_err;
    ext_err   = ext_ack && hold_err;
    cpu_rdata = cpu_ack ? resp_data : cpu_rdata_q;
    ext_rdata = ext_ack ? resp_data : ext_rdata_q;
    cpu_stall = cpu_req && !cpu_ack;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant  <= REQ_EXT;
      hold_id     <= REQ_CPU;
      hold_we     <= 1'b0;
      hold_err    <= 1'b0;
      hold_idx    <= '0;
      hold_be     <= 4'b0000;
      hold_wdata  <= 32'h0;
      cpu_rdata_q <= 32'h0;
      ext_rdata_q <= 32'h0;
    end else begin
      if (state == ST_IDLE && any_req) begin
        last_grant <= grant_id;
        hold_id    <= grant_id;
        hold_we    <= sel_we;
        hold_err   <= sel_err;
        hold_idx   <= sel_addr[ADDR_W+1:2];
        hold_be    <= sel_we ? gen_be : 4'b1111;
        hold_wdata <= gen_wdata;
      end
      if (cpu_ack) cpu_rdata_q <= resp_data;
      if (ext_ack) ext_rdata_q <= resp_data;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dm_arbiter.sv
// ---- tb_dm_arbiter : directed self-checking bench for dm_arbiter ---- Rev 1.0
`default_nettype none

module tb_dm_arbiter;

  logic        clk, reset, clr;
  logic        cpu_req, cpu_we, cpu_ack, cpu_err, cpu_stall;
  logic [2:0]  cpu_op;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        ext_req, ext_we, ext_ack, ext_err;
  logic [31:0] ext_addr, ext_wdata, ext_rdata;
  logic        mem_en, mem_we;
  logic [11:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;
  logic [31:0] mem_model [0:3071];

  int checks   = 0;
  int failures = 0;

  dm_arbiter #(.DEPTH(3072), .ADDR_W(12)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_op(cpu_op), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_ack(ext_ack), .ext_err(ext_err), .ext_rdata(ext_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte-lane synchronous memory
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 3072; i++) mem_model[i] <= 32'h0;
    end else if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we && mem_be[b]) mem_model[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      mem_rdata <= mem_model[mem_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cpu_set(input logic req, input logic we, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] wdata);
    cpu_req = req; cpu_we = we; cpu_op = op; cpu_addr = addr; cpu_wdata = wdata;
  endtask

  task automatic ext_set(input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
    ext_req = req; ext_we = we; ext_addr = addr; ext_wdata = wdata;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; clr = 1'b1;
    cpu_set(0, 0, 3'b000, 32'h0, 32'h0);
    ext_set(0, 0, 32'h0, 32'h0);
    tick();
    clr = 1'b0;
    tick();
    check("rst_cpu_ack",   cpu_ack,   0);
    check("rst_ext_ack",   ext_ack,   0);
    check("rst_mem_en",    mem_en,    0);
    check("rst_mem_addr",  mem_addr,  0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    reset = 1'b1;
    tick();

    // sw 0x10 DEADBEEF
    cpu_set(1, 1, 3'b000, 32'h10, 32'hDEADBEEF);
    #1 check("sw_stall_k", cpu_stall, 1);
    tick();
    check("sw_mem_en",    mem_en,    1);
    check("sw_mem_we",    mem_we,    1);
    check("sw_mem_addr",  mem_addr,  4);
    check("sw_mem_be",    mem_be,    4'hF);
    check("sw_mem_wdata", mem_wdata, 32'hDEADBEEF);
    check("sw_stall_k1",  cpu_stall, 1);
    check("sw_ack_early", cpu_ack,   0);
    tick();
    check("sw_ack",   cpu_ack,   1);
    check("sw_err",   cpu_err,   0);
    check("sw_stall", cpu_stall, 0);
    cpu_set(0, 0, 3'b000, 32'h0, 32'h0);
    tick();
    check("sw_ack_pulse", cpu_ack, 0);

    // sb 0x13 AB
    cpu_set(1, 1, 3'b001, 32'h13, 32'h000000AB);
    tick();
    check("sb_mem_be",    mem_be,    4'b1000);
    check("sb_mem_wdata", mem_wdata, 32'hABABABAB);
    tick();
    check("sb_ack", cpu_ack, 1);
    cpu_set(0, 0, 3'b000, 32'h0, 32'h0);
    tick();

    // lw 0x10 after byte merge
    cpu_set(1, 0, 3'b000, 32'h10, 32'h0);
    tick();
    check("lw_mem_we", mem_we, 0);
    check("lw_mem_be", mem_be, 4'hF);
    tick();
    check("lw_rdata", cpu_rdata, 32'hABADBEEF);
    cpu_set(0, 0, 3'b000, 32'h0, 32'h0);
    tick();
    check("lw_rdata_hold", cpu_rdata, 32'hABADBEEF);

    // sh 0x16 upper half
    cpu_set(1, 1, 3'b010, 32'h16, 32'h00001234);
    tick();
    check("sh_mem_be",    mem_be,    4'b1100);
    check("sh_mem_wdata", mem_wdata, 32'h12341234);
    check("sh_mem_addr",  mem_addr,  5);
    tick();
    cpu_set(0, 0, 3'b000, 32'h0, 32'h0);
    tick();

    // misaligned sh 0x11
    cpu_set(1, 1, 3'b010, 32'h11, 32'h00005555);
    tick();
    check("mis_mem_en", mem_en, 0);
    tick();
    check("mis_ack",   cpu_ack,   1);
    check("mis_err",   cpu_err,   1);
    check("mis_rdata", cpu_rdata, 0);
    cpu_set(0, 0, 3'b000, 32'h0, 32'h0);
    tick();
    check("mis_mem_unchanged", mem_model[4], 32'hABADBEEF);

    // illegal op
    cpu_set(1, 0, 3'b011, 32'h10, 32'h0);
    tick();
    check("ill_mem_en", mem_en, 0);
    tick();
    check("ill_err", cpu_err, 1);
    cpu_set(0, 0, 3'b000, 32'h0, 32'h0);
    tick();

    // ext lw out of range
    ext_set(1, 0, 32'h3000, 32'h0);
    tick();
    check("oor_mem_en", mem_en, 0);
    tick();
    check("oor_ack",   ext_ack,   1);
    check("oor_err",   ext_err,   1);
    check("oor_rdata", ext_rdata, 0);
    ext_set(0, 0, 32'h0, 32'h0);
    tick();

    // contention: cpu lw 0x10, ext sw 0x20
    cpu_set(1, 0, 3'b000, 32'h10, 32'h0);
    ext_set(1, 1, 32'h20, 32'h12345678);
    tick();
    check("arb1_mem_addr", mem_addr, 4);
    tick();
    check("arb1_cpu_ack", cpu_ack,   1);
    check("arb1_ext_ack", ext_ack,   0);
    check("arb1_mem_en",  mem_en,    0);
    check("arb1_rdata",   cpu_rdata, 32'hABADBEEF);
    tick();
    tick();
    check("arb2_mem_addr",  mem_addr,  8);
    check("arb2_mem_we",    mem_we,    1);
    check("arb2_mem_wdata", mem_wdata, 32'h12345678);
    tick();
    check("arb2_ext_ack", ext_ack, 1);
    check("arb2_cpu_ack", cpu_ack, 0);
    check("arb2_mem_en",  mem_en,  0);
    ext_set(0, 0, 32'h0, 32'h0);
    tick();
    tick();
    check("arb3_mem_addr", mem_addr, 4);
    tick();
    check("arb3_cpu_ack", cpu_ack, 1);
    check("arb3_ext_ack", ext_ack, 0);
    cpu_set(0, 0, 3'b000, 32'h0, 32'h0);
    tick();

    // ext lw 0x20
    ext_set(1, 0, 32'h20, 32'h0);
    tick();
    tick();
    check("ext_lw_rdata", ext_rdata, 32'h12345678);
    ext_set(0, 0, 32'h0, 32'h0);
    tick();

    // reset during ISSUE of ext sw 0x24
    ext_set(1, 1, 32'h24, 32'hCAFEF00D);
    tick();
    check("rsti_mem_en_pre", mem_en, 1);
    reset = 1'b0;
    #1 check("rsti_mem_en_drop", mem_en, 0);
    ext_set(0, 0, 32'h0, 32'h0);
    tick();
    check("rsti_ext_ack0", ext_ack, 0);
    tick();
    check("rsti_ext_ack1", ext_ack, 0);
    check("rsti_no_write", mem_model[9], 0);
    reset = 1'b1;
    tick();
    ext_set(1, 1, 32'h24, 32'hCAFEF00D);
    tick();
    check("rsti_reissue_we", mem_we, 1);
    tick();
    check("rsti_reissue_ack", ext_ack, 1);
    check("rsti_reissue_err", ext_err, 0);
    check("rsti_reissue_mem", mem_model[9], 32'hCAFEF00D);
    ext_set(0, 0, 32'h0, 32'h0);
    tick();

    // back-to-back cpu loads: ack every third cycle
    cpu_set(1, 0, 3'b000, 32'h10, 32'h0);
    for (int i = 1; i <= 12; i++) begin
      tick();
      check($sformatf("b2b_ack_c%0d", i), cpu_ack, (i % 3 == 2) ? 1 : 0);
      if (i == 11) cpu_set(0, 0, 3'b000, 32'h0, 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Sequences all accesses to the single-port data memory and shares it between two requesters.
- Requester 0 is the pipeline M stage (cpu); requester 1 is an external word-only master (ext), e.g. a program loader or debug port.
- Generates word index, byte-lane enables and merged write data for sw/sh/sb, so the memory array needs no read-modify-write.
- Checks alignment and range, and arbitrates round-robin with a req/ack handshake.

Parameters:
DEPTH, 3072, memory depth in 32-bit words.
ADDR_W, 12, word-index width; ceil(log2(DEPTH)).

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset (0 = reset)
cpu_req  in  1  cpu access request; held stable until cpu_ack
cpu_we  in  1  1 = store, 0 = load
cpu_op  in  3  000 word, 001 byte, 010 half; others illegal
cpu_addr  in  32  byte address
cpu_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
cpu_ack  out  1  one-cycle completion pulse
cpu_err  out  1  valid with cpu_ack: misaligned, out-of-range or illegal op
cpu_rdata  out  32  raw addressed word, valid with cpu_ack
cpu_stall  out  1  cpu_req & ~cpu_ack, combinational
ext_req  in  1  ext access request; held until ext_ack
ext_we  in  1  1 = store word
ext_addr  in  32  byte address
ext_wdata  in  32  store word
ext_ack  out  1  one-cycle completion pulse
ext_err  out  1  valid with ext_ack
ext_rdata  out  32  read word, valid with ext_ack
mem_en  out  1  memory access strobe
mem_we  out  1  write strobe, only while mem_en=1
mem_addr  out  ADDR_W  word index = addr[ADDR_W+1:2]
mem_be  out  4  byte-lane enables
mem_wdata  out  32  lane-replicated store data
mem_rdata  in  32  synchronous read; valid the cycle after mem_en

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, last_grant=ext, so cpu wins the first tie.
  - All outputs 0: acks, errs, rdata, mem_*.
  - An in-flight access is aborted. No write may occur once reset is asserted, because mem_en/mem_we are decoded from state.
- FSM states: IDLE, ISSUE, RESP.
  - IDLE: if any req is pending, grant and go to ISSUE.
    - Only one pending: grant it.
    - Both pending: grant the requester opposite last_grant; update last_grant.
    - Latch the granted request's fields into a holding register.
  - ISSUE: drive mem_* from the holding register for exactly one cycle; go to RESP.
  - RESP: capture mem_rdata into the granted rdata register; pulse the granted ack; go to IDLE.
- Latency: req sampled in IDLE at edge k -> mem_en high in cycle k+1 -> ack high in cycle k+2. Uncontended throughput is one access per 3 cycles.
- Requests must stay asserted and stable until ack.
  - A requester that drops req before ack still receives the ack; the access completes.
  - A req still high in the cycle after ack is treated as a new request.
- Error check at grant; error conditions:
  - word with addr[1:0]!=0;
  - half with addr[0]!=0;
  - op not in {000,001,010};
  - addr[31:2] >= DEPTH.
  Effect: no memory access (mem_en stays 0 in ISSUE); ack is still pulsed in RESP with err=1 and rdata=0.
- Byte lanes, with a = addr[1:0]:
  - word: be=1111, wdata=data.
  - half: be=0011 if a[1]=0, else 1100; wdata={2{data[15:0]}}.
  - byte: be=0001<<a; wdata={4{data[7:0]}}.
  - Loads: be=1111, mem_we=0.
- ext accesses are always word-sized; the op field is forced to 000 internally.
- cpu_rdata/ext_rdata hold their value until the next ack to the same requester.
- Address bits above the range check are ignored; the index uses addr[ADDR_W+1:2] only.

Decomposition:
- Shared package holds:
  - op encodings (OP_W=3'b000, OP_B=3'b001, OP_H=3'b010);
  - FSM state encodings;
  - requester IDs.
- One natural sub-module: dm_lane_gen. It is combinational: (op, addr[1:0], wdata) -> (be, lane_wdata, misalign). It is reused by any future cache fill path.

Test Plan:
- Reset release, cpu sw addr=0x10 data=0xDEADBEEF -> mem_en/mem_we at k+1, mem_addr=4, be=1111; cpu_ack at k+2, err=0; cpu_stall high for cycles k..k+1.
- cpu sb addr=0x13 data=0x000000AB -> be=1000, mem_wdata=0xABABABAB; then cpu lw 0x10 with mem model -> cpu_rdata=0xABADBEEF.
- cpu sh addr=0x11 -> no mem_en, cpu_ack with cpu_err=1, memory unchanged. ext lw addr=0x3000 (word 3072 >= DEPTH) -> ext_err=1.
- cpu_req and ext_req rise in the same cycle, both held through three successive accesses -> grants cpu, ext, cpu in order; no overlapping mem_en.
- reset pulled low during ISSUE of an ext sw -> mem_en drops immediately, no write, ext_ack never pulses; after release, a re-issued request completes normally.
- Back-to-back: cpu_req held continuously across 4 accesses -> one ack every 3 cycles, each ack a single-cycle pulse.
